// File: rtl/keylog_display_ctrl.sv
// Shares the six-digit 7-segment bus between the live HID sniffer view and a
// browsable history of report changes held in a small circular log.
module keylog_display_ctrl #(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned ADDR_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        modifier,
    input  logic [7:0]        keycode,
    input  logic [3:0]        leds,
    input  logic              step_n,
    input  logic              mode_hist,
    input  logic              clear,
    output logic [23:0]       dig_out,
    output logic [ADDR_W:0]   entry_count,
    output logic              overflow,
    output logic [ADDR_W-1:0] view_idx
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        LIVE = 1'b0,
        HIST = 1'b1
    } state_e;

    state_e            state_q;
    logic              sync1_q, sync2_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              db_lvl_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [15:0]       last_q;
    logic [CNT_W-1:0]  entry_count_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] view_idx_q;
    logic [23:0]       dig_out_q;
    logic [15:0]       mem_q [DEPTH];

    logic              db_hit_c;
    logic              step_c;
    logic [15:0]       cur_c;
    logic              cap_c;
    logic              full_c;
    logic [CNT_W-1:0]  entry_count_d;
    logic [CNT_W-1:0]  idx_cap_c;
    logic [CNT_W-1:0]  idx_step_c;
    logic [ADDR_W-1:0] view_hist_d;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [15:0]       entry_c;
    logic [23:0]       dig_out_d;

    // Debounce: the counter only runs while the synchronized input disagrees
    // with the accepted level, so any glitch back to the old level restarts it.
    assign db_hit_c = (sync2_q != db_lvl_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
    assign step_c   = db_hit_c && db_lvl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            db_cnt_q <= '0;
            db_lvl_q <= 1'b1;
        end else begin
            sync1_q <= step_n;
            sync2_q <= sync1_q;
            if (sync2_q == db_lvl_q) begin
                db_cnt_q <= '0;
            end else if (db_hit_c) begin
                db_lvl_q <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign cur_c  = {modifier, keycode};
    assign cap_c  = (cur_c != last_q) && !clear;
    assign full_c = (entry_count_q == CNT_W'(DEPTH));

    always_comb begin
        entry_count_d = entry_count_q;
        if (cap_c && !full_c) begin
            entry_count_d = entry_count_q + CNT_W'(1);
        end
    end

    // History index: a capture pushes the viewed entry one slot older, then a
    // step advances from there and wraps past the oldest valid entry.
    always_comb begin
        idx_cap_c = CNT_W'(view_idx_q);
        if (cap_c && (entry_count_q != '0) && (view_idx_q != ADDR_W'(DEPTH - 1))) begin
            idx_cap_c = CNT_W'(view_idx_q) + CNT_W'(1);
        end
        idx_step_c = idx_cap_c;
        if (step_c) begin
            if ((idx_cap_c + CNT_W'(1)) >= entry_count_d) begin
                idx_step_c = '0;
            end else begin
                idx_step_c = idx_cap_c + CNT_W'(1);
            end
        end
        view_hist_d = ADDR_W'(idx_step_c);
    end

    assign rd_addr_c = wr_ptr_q - ADDR_W'(1) - view_idx_q;
    assign entry_c   = mem_q[rd_addr_c];

    always_comb begin
        dig_out_d = {cur_c, leds, 4'h0};
        if (state_q == HIST) begin
            if (entry_count_q == '0) begin
                dig_out_d = 24'h00000E;
            end else begin
                dig_out_d = {entry_c, 4'(view_idx_q), 4'hF};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_c && !rst) begin
            mem_q[wr_ptr_q] <= cur_c;
        end
    end

    // View state machine plus log bookkeeping; clear overrides capture and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LIVE;
            wr_ptr_q      <= '0;
            last_q        <= cur_c;
            entry_count_q <= '0;
            overflow_q    <= 1'b0;
            view_idx_q    <= '0;
            dig_out_q     <= 24'h888888;
        end else begin
            dig_out_q <= dig_out_d;

            case (state_q)
                LIVE: begin
                    if (mode_hist) begin
                        state_q    <= HIST;
                        view_idx_q <= '0;
                    end
                end
                HIST: begin
                    if (!mode_hist) begin
                        state_q    <= LIVE;
                        view_idx_q <= '0;
                    end else begin
                        view_idx_q <= view_hist_d;
                    end
                end
                default: begin
                    state_q    <= LIVE;
                    view_idx_q <= '0;
                end
            endcase

            if (clear) begin
                wr_ptr_q      <= '0;
                last_q        <= cur_c;
                entry_count_q <= '0;
                overflow_q    <= 1'b0;
                view_idx_q    <= '0;
            end else if (cap_c) begin
                wr_ptr_q      <= wr_ptr_q + ADDR_W'(1);
                last_q        <= cur_c;
                entry_count_q <= entry_count_d;
                if (full_c) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign dig_out     = dig_out_q;
    assign entry_count = entry_count_q;
    assign overflow    = overflow_q;
    assign view_idx    = view_idx_q;

endmodule
